hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_if.sv | 29 ++
 rtl/hazard_controller.sv | 110 +++++++++++
 tb/tb_hazard_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Decode-stage hazard interface: decode-side request fields in,
// stall/bubble/issue decisions and the stall counter out.
interface hazard_controller_if;
  logic        dec_valid;
  logic [2:0]  dec_rs1;
  logic [2:0]  dec_rs2;
  logic        dec_rs1_used;
  logic        dec_rs2_used;
  logic        dec_wb;
  logic [2:0]  dec_rd;
  logic        flush;
  logic        stall;
  logic        bubble;
  logic        issue;
  logic [1:0]  hazard_stage;
  logic [15:0] stall_count;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_wb, dec_rd, flush,
    input  stall, bubble, issue, hazard_stage, stall_count
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_wb, dec_rd, flush,
    output stall, bubble, issue, hazard_stage, stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Scoreboard-based RAW hazard detector for a decode stage feeding a
// 3-stage EX/MEM/WB pipeline with no forwarding. A decode instruction
// stalls while any in-flight stage holds a pending write to a register
// it reads; the scoreboard shifts every cycle, inserting v=0 on bubbles.
module hazard_controller #(
  parameter int unsigned SB_DEPTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  hazard_controller_if.slave bus
);

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
  } sb_entry_t;

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  // Index 0 = EX (youngest), 1 = MEM, 2 = WB (oldest).
  sb_entry_t           sb [SB_DEPTH];
  logic [SB_DEPTH-1:0] conflict;
  logic [1:0]          youngest;
  logic                hazard;
  logic                issue;
  state_t              state;
  state_t              state_nxt;
  logic                count_en;
  logic [15:0]         stall_count_q;

  // Per-stage match of either used source against a pending write.
  always_comb begin
    conflict = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      conflict[i] = sb[i].v &&
                    ((bus.dec_rs1_used && (sb[i].rd == bus.dec_rs1)) ||
                     (bus.dec_rs2_used && (sb[i].rd == bus.dec_rs2)));
    end
  end

  // Hazard decision; the scan runs oldest to youngest so the youngest
  // conflicting stage overwrites any older one.
  always_comb begin
    youngest = '0;
    for (int unsigned i = SB_DEPTH; i > 0; i--) begin
      if (conflict[i-1]) youngest = 2'(i);
    end
    // Reset and flush both mask the hazard so neither can stall.
    hazard = !reset && bus.dec_valid && !bus.flush && (|conflict);
    issue  = !reset && bus.dec_valid && !bus.flush && !hazard;
  end

  assign bus.stall        = hazard;
  assign bus.issue        = issue;
  assign bus.bubble       = !issue;
  assign bus.hazard_stage = hazard ? youngest : '0;
  assign bus.stall_count  = stall_count_q;

  // Scoreboard shift: a new EX entry is valid only for an issued writer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        sb[i] <= '0;
      end
    end else begin
      sb[0] <= '{v: issue && bus.dec_wb, rd: bus.dec_rd};
      for (int unsigned i = 1; i < SB_DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  // RUN/STALL state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state logic; every cycle spent stalling enables the counter.
  always_comb begin
    state_nxt = state;
    count_en  = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          state_nxt = STALL;
          count_en  = 1'b1;
        end
      end
      STALL: begin
        if (hazard) count_en  = 1'b1;
        else        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (count_en && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a queue-based reference of recently
// issued register writes predicts every output each cycle, with
// directed scenarios pinning literal values and a random phase.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_controller_if bus ();

  hazard_controller #(.SB_DEPTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Destination of each instruction that entered EX in the last three
  // cycles, youngest first; -1 marks a cycle that wrote nothing.
  int wq[$];
  int exp_cnt  = 0;
  bit started  = 1'b0;
  int run_len  = 0;

  task automatic chk(string name, logic [16:0] act, logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_stage();
    for (int k = 0; k < wq.size(); k++) begin
      if (wq[k] >= 0 &&
          ((bus.dec_rs1_used && wq[k] == int'(bus.dec_rs1)) ||
           (bus.dec_rs2_used && wq[k] == int'(bus.dec_rs2))))
        return k + 1;
    end
    return 0;
  endfunction

  function automatic bit exp_hazard();
    return !reset && bus.dec_valid && !bus.flush && (exp_stage() != 0);
  endfunction

  function automatic bit exp_issue();
    return !reset && bus.dec_valid && !bus.flush && !exp_hazard();
  endfunction

  // Reference model update at each rising edge.
  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      wq.delete();
      exp_cnt <= 0;
    end else begin
      if (exp_hazard() && exp_cnt < 65535) exp_cnt <= exp_cnt + 1;
      wq.push_front((exp_issue() && bus.dec_wb) ? int'(bus.dec_rd) : -1);
      if (wq.size() > 3) void'(wq.pop_back());
    end
  end

  // Compare process: every cycle after the first edge.
  always @(negedge clk) begin
    if (started) begin
      chk("stall", 17'(bus.stall), 17'(exp_hazard()));
      chk("bubble", 17'(bus.bubble),
          17'(exp_hazard() || bus.flush || !bus.dec_valid || reset));
      chk("issue", 17'(bus.issue), 17'(exp_issue()));
      chk("hazard_stage", 17'(bus.hazard_stage),
          exp_hazard() ? 17'(exp_stage()) : 17'd0);
      chk("stall_count", 17'(bus.stall_count), 17'(exp_cnt));
      if (bus.stall === 1'b1) begin
        chk("stall_run_le3", 17'(run_len + 1 > 3), 17'd0);
        run_len <= run_len + 1;
      end else begin
        run_len <= 0;
      end
    end
  end

  task automatic drive(bit r, bit v, logic [2:0] rs1, bit u1, logic [2:0] rs2,
                       bit u2, bit wb, logic [2:0] rd, bit fl);
    @(posedge clk);
    #1;
    reset            = r;
    bus.dec_valid    = v;
    bus.dec_rs1      = rs1;
    bus.dec_rs1_used = u1;
    bus.dec_rs2      = rs2;
    bus.dec_rs2_used = u2;
    bus.dec_wb       = wb;
    bus.dec_rd       = rd;
    bus.flush        = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic wr(logic [2:0] rd);
    drive(0, 1, 3'd0, 0, 3'd0, 0, 1, rd, 0);
  endtask

  task automatic nop_instr();
    drive(0, 1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0);
  endtask

  task automatic rd_rs1(logic [2:0] rs, bit fl);
    drive(0, 1, rs, 1, 3'd0, 0, 0, 3'd0, fl);
  endtask

  task automatic lit(string name, bit st, bit is, bit bu, logic [1:0] hs);
    chk({name, "_stall"}, 17'(bus.stall), 17'(st));
    chk({name, "_issue"}, 17'(bus.issue), 17'(is));
    chk({name, "_bubble"}, 17'(bus.bubble), 17'(bu));
    chk({name, "_stage"}, 17'(bus.hazard_stage), 17'(hs));
  endtask

  initial begin
    reset            = 1'b1;
    bus.dec_valid    = 1'b0;
    bus.dec_rs1      = '0;
    bus.dec_rs1_used = 1'b0;
    bus.dec_rs2      = '0;
    bus.dec_rs2_used = 1'b0;
    bus.dec_wb       = 1'b0;
    bus.dec_rd       = '0;
    bus.flush        = 1'b0;

    drive(1, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0);
    drive(1, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0);
    lit("reset", 0, 0, 1, 2'd0);
    chk("reset_count", 17'(bus.stall_count), 17'd0);
    drive(0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0);
    lit("idle", 0, 0, 1, 2'd0);

    // Back-to-back dependency on R3.
    wr(3'd3);
    lit("b2b_prod", 0, 1, 0, 2'd0);
    rd_rs1(3'd3, 0);
    lit("b2b_s1", 1, 0, 1, 2'd1);
    rd_rs1(3'd3, 0);
    lit("b2b_s2", 1, 0, 1, 2'd2);
    rd_rs1(3'd3, 0);
    lit("b2b_s3", 1, 0, 1, 2'd3);
    rd_rs1(3'd3, 0);
    lit("b2b_go", 0, 1, 0, 2'd0);
    chk("b2b_count", 17'(bus.stall_count), 17'd3);

    // Producer two instructions ahead: stalls once against WB.
    wr(3'd5);
    nop_instr();
    nop_instr();
    drive(0, 1, 3'd0, 0, 3'd5, 1, 0, 3'd0, 0);
    lit("gap_s1", 1, 0, 1, 2'd3);
    drive(0, 1, 3'd0, 0, 3'd5, 1, 0, 3'd0, 0);
    lit("gap_go", 0, 1, 0, 2'd0);
    chk("gap_count", 17'(bus.stall_count), 17'd4);

    // Unused rs2 matching a pending EX write.
    wr(3'd2);
    drive(0, 1, 3'd0, 0, 3'd2, 0, 0, 3'd0, 0);
    lit("unused", 0, 1, 0, 2'd0);

    // Flush in the second stall cycle; the producer keeps draining.
    wr(3'd1);
    rd_rs1(3'd1, 0);
    lit("fl_s1", 1, 0, 1, 2'd1);
    rd_rs1(3'd1, 1);
    lit("fl_flush", 0, 0, 1, 2'd0);
    rd_rs1(3'd1, 0);
    lit("fl_wb", 1, 0, 1, 2'd3);
    rd_rs1(3'd1, 0);
    lit("fl_go", 0, 1, 0, 2'd0);

    // Destination equal to own source is not a conflict.
    drive(0, 1, 3'd4, 1, 3'd4, 1, 1, 3'd4, 0);
    lit("self", 0, 1, 0, 2'd0);

    // Two sources against two stages.
    wr(3'd6);
    wr(3'd7);
    drive(0, 1, 3'd6, 1, 3'd7, 1, 0, 3'd0, 0);
    lit("dual_s1", 1, 0, 1, 2'd1);
    drive(0, 1, 3'd6, 1, 3'd7, 1, 0, 3'd0, 0);
    lit("dual_s2", 1, 0, 1, 2'd2);
    drive(0, 1, 3'd6, 1, 3'd7, 1, 0, 3'd0, 0);
    lit("dual_s3", 1, 0, 1, 2'd3);
    drive(0, 1, 3'd6, 1, 3'd7, 1, 0, 3'd0, 0);
    lit("dual_go", 0, 1, 0, 2'd0);

    // Reset in the second stall cycle.
    wr(3'd1);
    rd_rs1(3'd1, 0);
    lit("rst_s1", 1, 0, 1, 2'd1);
    drive(1, 1, 3'd1, 1, 3'd0, 0, 0, 3'd0, 0);
    lit("rst_during", 0, 0, 1, 2'd0);
    rd_rs1(3'd1, 0);
    lit("rst_after", 0, 1, 0, 2'd0);
    chk("rst_count", 17'(bus.stall_count), 17'd0);

    // Independent stream: write Rn, read R(n+4).
    for (int n = 0; n < 10; n++) begin
      drive(0, 1, 3'((n + 4) % 8), 1, 3'd0, 0, 1, 3'(n % 8), 0);
      lit("indep", 0, 1, 0, 2'd0);
    end

    // Random traffic checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 85),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0));
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
